// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB broadcast and issue bus between the dispatcher/ALU and the
// ALU reservation station.
interface alu_reservation_station_if #(
  parameter int OP_W   = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              rdy;
  logic              in_clear;
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_value1;
  logic [DATA_W-1:0] in_value2;
  logic [TAG_W-1:0]  in_tag1;
  logic [TAG_W-1:0]  in_tag2;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_pc;
  logic [TAG_W-1:0]  in_rob_tag;
  logic [TAG_W-1:0]  alu_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_value;
  logic [TAG_W-1:0]  lsb_cdb_tag;
  logic [DATA_W-1:0] lsb_cdb_value;
  logic              out_full;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_value1;
  logic [DATA_W-1:0] out_value2;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_pc;
  logic [TAG_W-1:0]  out_rob_tag;

  modport master (
    output rdy, in_clear, in_valid, in_op, in_value1, in_value2, in_tag1, in_tag2,
           in_imm, in_pc, in_rob_tag, alu_cdb_tag, alu_cdb_value, lsb_cdb_tag, lsb_cdb_value,
    input  out_full, out_op, out_value1, out_value2, out_imm, out_pc, out_rob_tag
  );

  modport slave (
    input  rdy, in_clear, in_valid, in_op, in_value1, in_value2, in_tag1, in_tag2,
           in_imm, in_pc, in_rob_tag, alu_cdb_tag, alu_cdb_value, lsb_cdb_tag, lsb_cdb_value,
    output out_full, out_op, out_value1, out_value2, out_imm, out_pc, out_rob_tag
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops, captures operands from the
// ALU and LSB CDB ports, and issues the lowest-indexed ready op each cycle.
module alu_reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_reservation_station_if.slave rs
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [DATA_W-1:0]  v1_q  [RS_SIZE];
  logic [DATA_W-1:0]  v2_q  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [DATA_W-1:0]  pc_q  [RS_SIZE];
  logic [TAG_W-1:0]   t1_q  [RS_SIZE];
  logic [TAG_W-1:0]   t2_q  [RS_SIZE];
  logic [TAG_W-1:0]   rob_q [RS_SIZE];

  logic [OP_W-1:0]    out_op_q;
  logic [DATA_W-1:0]  out_v1_q, out_v2_q, out_imm_q, out_pc_q;
  logic [TAG_W-1:0]   out_rob_q;

  logic               full, sel_found, dispatch_en;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic [TAG_W-1:0]   disp_t1, disp_t2;
  logic [DATA_W-1:0]  disp_v1, disp_v2;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [TAG_W-1:0] cdb_tag);
    return (tag != '0) && (tag == cdb_tag);
  endfunction

  assign full        = &busy_q;
  assign dispatch_en = rs.in_valid && !full && !rs.in_clear;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (busy_q[i] && (t1_q[i] == '0) && (t2_q[i] == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Same-cycle forwarding into the dispatched entry; ALU port wins a double hit.
  always_comb begin
    disp_t1 = rs.in_tag1;
    disp_v1 = rs.in_value1;
    disp_t2 = rs.in_tag2;
    disp_v2 = rs.in_value2;
    if (cdb_hit(rs.in_tag1, rs.alu_cdb_tag)) begin
      disp_t1 = '0;
      disp_v1 = rs.alu_cdb_value;
    end else if (cdb_hit(rs.in_tag1, rs.lsb_cdb_tag)) begin
      disp_t1 = '0;
      disp_v1 = rs.lsb_cdb_value;
    end
    if (cdb_hit(rs.in_tag2, rs.alu_cdb_tag)) begin
      disp_t2 = '0;
      disp_v2 = rs.alu_cdb_value;
    end else if (cdb_hit(rs.in_tag2, rs.lsb_cdb_tag)) begin
      disp_t2 = '0;
      disp_v2 = rs.lsb_cdb_value;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (sel_found)   busy_d[sel_idx]  = 1'b0;
    if (dispatch_en) busy_d[free_idx] = 1'b1;
    if (rs.in_clear) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      out_op_q  <= '0;
      out_v1_q  <= '0;
      out_v2_q  <= '0;
      out_imm_q <= '0;
      out_pc_q  <= '0;
      out_rob_q <= '0;
    end else if (rs.rdy) begin
      busy_q <= busy_d;
      if (sel_found && !rs.in_clear) begin
        out_op_q  <= op_q[sel_idx];
        out_v1_q  <= v1_q[sel_idx];
        out_v2_q  <= v2_q[sel_idx];
        out_imm_q <= imm_q[sel_idx];
        out_pc_q  <= pc_q[sel_idx];
        out_rob_q <= rob_q[sel_idx];
      end else begin
        out_op_q  <= '0;
        out_v1_q  <= '0;
        out_v2_q  <= '0;
        out_imm_q <= '0;
        out_pc_q  <= '0;
        out_rob_q <= '0;
      end
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rs.rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cdb_hit(t1_q[i], rs.alu_cdb_tag)) begin
          v1_q[i] <= rs.alu_cdb_value;
          t1_q[i] <= '0;
        end else if (cdb_hit(t1_q[i], rs.lsb_cdb_tag)) begin
          v1_q[i] <= rs.lsb_cdb_value;
          t1_q[i] <= '0;
        end
        if (cdb_hit(t2_q[i], rs.alu_cdb_tag)) begin
          v2_q[i] <= rs.alu_cdb_value;
          t2_q[i] <= '0;
        end else if (cdb_hit(t2_q[i], rs.lsb_cdb_tag)) begin
          v2_q[i] <= rs.lsb_cdb_value;
          t2_q[i] <= '0;
        end
      end
      if (dispatch_en) begin
        op_q[free_idx]  <= rs.in_op;
        v1_q[free_idx]  <= disp_v1;
        t1_q[free_idx]  <= disp_t1;
        v2_q[free_idx]  <= disp_v2;
        t2_q[free_idx]  <= disp_t2;
        imm_q[free_idx] <= rs.in_imm;
        pc_q[free_idx]  <= rs.in_pc;
        rob_q[free_idx] <= rs.in_rob_tag;
      end
    end
  end

  assign rs.out_full    = full;
  assign rs.out_op      = out_op_q;
  assign rs.out_value1  = out_v1_q;
  assign rs.out_value2  = out_v2_q;
  assign rs.out_imm     = out_imm_q;
  assign rs.out_pc      = out_pc_q;
  assign rs.out_rob_tag = out_rob_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a vector table for single-op
// flows plus hand sequences for fill, clear, rdy freeze and async reset.
module tb_alu_reservation_station;
  localparam int RS_SIZE = 16;
  localparam int OP_W    = 6;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int NVEC    = 21;

  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [3:0]  Z4  = 4'h0;
  localparam logic [5:0]  NOP = 6'd0;

  typedef struct {
    logic        vld;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic [31:0] v2;
    logic [3:0]  t2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic [3:0]  at;
    logic [31:0] av;
    logic [3:0]  lt;
    logic [31:0] lv;
    logic [5:0]  eop;
    logic [31:0] ev1;
    logic [31:0] ev2;
    logic [31:0] eimm;
    logic [31:0] epc;
    logic [3:0]  erob;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vt [NVEC];

  always #5 clk = ~clk;

  alu_reservation_station_if #(.OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  alu_reservation_station #(
    .RS_SIZE(RS_SIZE), .OP_W(OP_W), .DATA_W(DATA_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rs (bus)
  );

  task automatic idle();
    bus.rdy           = 1'b1;
    bus.in_clear      = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_op         = NOP;
    bus.in_value1     = Z32;
    bus.in_value2     = Z32;
    bus.in_tag1       = Z4;
    bus.in_tag2       = Z4;
    bus.in_imm        = Z32;
    bus.in_pc         = Z32;
    bus.in_rob_tag    = Z4;
    bus.alu_cdb_tag   = Z4;
    bus.alu_cdb_value = Z32;
    bus.lsb_cdb_tag   = Z4;
    bus.lsb_cdb_value = Z32;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] t1,
                      input logic [31:0] v2, input logic [3:0] t2, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [3:0] rob);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_value1  = v1;
    bus.in_tag1    = t1;
    bus.in_value2  = v2;
    bus.in_tag2    = t2;
    bus.in_imm     = imm;
    bus.in_pc      = pc;
    bus.in_rob_tag = rob;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic ef, input logic [5:0] eop,
                       input logic [31:0] ev1, input logic [31:0] ev2, input logic [31:0] eimm,
                       input logic [31:0] epc, input logic [3:0] erob);
    n_vec++;
    if ({bus.out_full, bus.out_op, bus.out_value1, bus.out_value2, bus.out_imm, bus.out_pc,
         bus.out_rob_tag} !== {ef, eop, ev1, ev2, eimm, epc, erob}) begin
      n_err++;
      $display("FAIL %s: got full=%b op=%0d v1=%h v2=%h imm=%h pc=%h rob=%0d, want full=%b op=%0d v1=%h v2=%h imm=%h pc=%h rob=%0d",
               name, bus.out_full, bus.out_op, bus.out_value1, bus.out_value2, bus.out_imm,
               bus.out_pc, bus.out_rob_tag, ef, eop, ev1, ev2, eimm, epc, erob);
    end
  endtask

  task automatic check_nop(input string name, input logic ef);
    check(name, ef, NOP, Z32, Z32, Z32, Z32, Z4);
  endtask

  initial begin
    // vld op v1 t1 v2 t2 imm pc rob | at av lt lv | eop ev1 ev2 eimm epc erob
    vt[0]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[1]  = '{1'b1, 6'd3,  32'h5,    Z4,   Z32,      Z4,   32'h7, 32'h100,   4'd3,  Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[2]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      6'd3,  32'h5,    Z32,      32'h7, 32'h100,   4'd3};
    vt[3]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[4]  = '{1'b1, 6'd1,  32'hDEAD, 4'd4, 32'h9,    Z4,   Z32,   32'h104,   4'd5,  Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[5]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[6]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      4'd3, 32'hFF,   NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[7]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[8]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    4'd4, 32'h11,   Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[9]  = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      6'd1,  32'h11,   32'h9,    Z32,   32'h104,   4'd5};
    vt[10] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[11] = '{1'b1, 6'd2,  32'h1,    Z4,   Z32,      4'd6, Z32,   32'h108,   4'd7,  Z4,   Z32,      4'd6, 32'hAB,   NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[12] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      6'd2,  32'h1,    32'hAB,   Z32,   32'h108,   4'd7};
    vt[13] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[14] = '{1'b1, 6'd4,  Z32,      4'd2, 32'h3,    Z4,   Z32,   32'h10C,   4'd9,  4'd2, 32'h22,   4'd2, 32'h33,   NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[15] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      6'd4,  32'h22,   32'h3,    Z32,   32'h10C,   4'd9};
    vt[16] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[17] = '{1'b1, 6'd5,  32'h7,    Z4,   Z32,      4'd8, 32'h1, 32'h110,   4'd10, Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[18] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      4'd8, 32'h55,   NOP,   Z32,      Z32,      Z32,   Z32,       Z4};
    vt[19] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      6'd5,  32'h7,    32'h55,   32'h1, 32'h110,   4'd10};
    vt[20] = '{1'b0, NOP,   Z32,      Z4,   Z32,      Z4,   Z32,   Z32,       Z4,    Z4,   Z32,      Z4,   Z32,      NOP,   Z32,      Z32,      Z32,   Z32,       Z4};

    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check_nop("reset", 1'b0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      idle();
      if (vt[i].vld)
        disp(vt[i].op, vt[i].v1, vt[i].t1, vt[i].v2, vt[i].t2, vt[i].imm, vt[i].pc, vt[i].rob);
      bus.alu_cdb_tag   = vt[i].at;
      bus.alu_cdb_value = vt[i].av;
      bus.lsb_cdb_tag   = vt[i].lt;
      bus.lsb_cdb_value = vt[i].lv;
      step();
      check($sformatf("vec%0d", i), 1'b0, vt[i].eop, vt[i].ev1, vt[i].ev2, vt[i].eimm,
            vt[i].epc, vt[i].erob);
    end

    // Fill all entries behind an unresolved tag, then drain in index order.
    idle();
    for (int i = 0; i < RS_SIZE; i++) begin
      disp(6'd20, Z32, 4'd1, Z32, Z4, 32'(i), 32'h200 + 32'(i) * 4, 4'(i));
      step();
      if (i == RS_SIZE - 2) check_nop("fill15", 1'b0);
    end
    check_nop("full16", 1'b1);
    disp(6'd21, 32'h1, Z4, 32'h2, Z4, Z32, 32'hBAD, 4'd15);
    step();
    check_nop("drop17", 1'b1);
    idle();
    bus.alu_cdb_tag   = 4'd1;
    bus.alu_cdb_value = 32'h77;
    step();
    check_nop("wake_all", 1'b1);
    idle();
    for (int k = 0; k < RS_SIZE; k++) begin
      step();
      check($sformatf("issue%0d", k), 1'b0, 6'd20, 32'h77, Z32, 32'(k),
            32'h200 + 32'(k) * 4, 4'(k));
    end
    step();
    check_nop("after_drain", 1'b0);

    // Clear beats a simultaneous dispatch and a ready-to-issue entry.
    for (int i = 0; i < 3; i++) begin
      disp(6'd22, Z32, 4'd1, Z32, Z4, Z32, 32'h400 + 32'(i) * 4, 4'(i + 1));
      step();
    end
    disp(6'd23, 32'h5, Z4, 32'h6, Z4, Z32, 32'h40C, 4'd13);
    step();
    check_nop("pre_clear", 1'b0);
    idle();
    disp(6'd24, 32'h1, Z4, 32'h2, Z4, Z32, 32'h410, 4'd12);
    bus.in_clear = 1'b1;
    step();
    check_nop("clear", 1'b0);
    idle();
    bus.alu_cdb_tag   = 4'd1;
    bus.alu_cdb_value = 32'h99;
    step();
    check_nop("clr_wake", 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check_nop($sformatf("clr_quiet%0d", i), 1'b0);
    end

    // rdy low freezes dispatch, wakeup and the output registers.
    disp(6'd10, Z32, 4'd3, 32'h4, Z4, Z32, 32'h500, 4'd1);
    step();
    check_nop("rdy_a", 1'b0);
    disp(6'd9, 32'h9, Z4, 32'h8, Z4, 32'h2, 32'h504, 4'd2);
    step();
    check_nop("rdy_b", 1'b0);
    disp(6'd11, 32'hB, Z4, 32'hC, Z4, 32'h3, 32'h508, 4'd4);
    step();
    check("rdy_c", 1'b0, 6'd9, 32'h9, 32'h8, 32'h2, 32'h504, 4'd2);
    idle();
    disp(6'd12, 32'hE, Z4, 32'hF, Z4, Z32, 32'h50C, 4'd5);
    bus.rdy           = 1'b0;
    bus.alu_cdb_tag   = 4'd3;
    bus.alu_cdb_value = 32'h33;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("frz%0d", i), 1'b0, 6'd9, 32'h9, 32'h8, 32'h2, 32'h504, 4'd2);
    end
    idle();
    step();
    check("thaw_issue", 1'b0, 6'd11, 32'hB, 32'hC, 32'h3, 32'h508, 4'd4);
    step();
    check_nop("no_wake", 1'b0);
    bus.alu_cdb_tag   = 4'd3;
    bus.alu_cdb_value = 32'h33;
    step();
    check_nop("late_wake", 1'b0);
    idle();
    step();
    check("late_issue", 1'b0, 6'd10, 32'h33, 32'h4, Z32, 32'h500, 4'd1);
    step();
    check_nop("frz_nodisp", 1'b0);

    // Asynchronous reset mid-cycle discards outputs and entries at once.
    disp(6'd13, Z32, 4'd5, Z32, Z4, Z32, 32'h600, 4'd6);
    step();
    disp(6'd12, 32'h12, Z4, 32'h34, Z4, 32'h56, 32'h604, 4'd7);
    step();
    idle();
    step();
    check("pre_rst", 1'b0, 6'd12, 32'h12, 32'h34, 32'h56, 32'h604, 4'd7);
    #2 rst = 1'b0;
    #1 check_nop("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.alu_cdb_tag   = 4'd5;
    bus.alu_cdb_value = 32'h1;
    step();
    check_nop("rst_wake", 1'b0);
    idle();
    step();
    check_nop("rst_quiet", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station directly upstream of the combinational ALU in the out-of-order RISC-V core. It buffers dispatched ALU/branch/jump ops and captures missing operands from the two CDB broadcast ports (ALU result, load/store buffer result). Each cycle it issues at most one op whose operands are both ready to the ALU, which returns the result tagged with the same ROB tag. Tag value 0 means "no dependency / no broadcast".

Parameters:
RS_SIZE, 16, number of entries (power of two, 2..32)
OP_W, 6, internal opcode width; opcode 0 is NOP
DATA_W, 32, operand/data width
TAG_W, 4, ROB tag width; tag 0 reserved as null

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
rdy  input  1  global ready; low freezes all state
in_clear  input  1  ROB flush on misprediction
in_valid  input  1  dispatch strobe
in_op  input  OP_W  dispatched opcode
in_value1 / in_value2  input  DATA_W  operand values (valid when matching tag is 0)
in_tag1 / in_tag2  input  TAG_W  producer ROB tags, 0 = value ready
in_imm  input  DATA_W  immediate
in_pc  input  DATA_W  instruction PC
in_rob_tag  input  TAG_W  destination ROB tag
alu_cdb_tag / lsb_cdb_tag  input  TAG_W  broadcast tags, 0 = idle
alu_cdb_value / lsb_cdb_value  input  DATA_W  broadcast values
out_full  output  1  all entries busy
out_op  output  OP_W  issued opcode, NOP when idle
out_value1 / out_value2 / out_imm / out_pc  output  DATA_W  issued fields
out_rob_tag  output  TAG_W  issued ROB tag, 0 when idle

Behaviour:
- Reset (rst low, async): all entries free; out_op=NOP, all other outputs 0, out_full=0. Reset mid-operation discards all entries immediately.
- Clock and reset: one clock; reset is asynchronous and active-low.
- rdy low: no entry, wakeup or output register changes; outputs hold.
- Entry state: busy, op, v1, t1, v2, t2, imm, pc, rob_tag.
- out_full is combinational from registered busy bits: high iff all RS_SIZE entries are busy. An entry freed by issue in the same cycle does not clear out_full until the next cycle.
- Dispatch: when in_valid && !out_full && !in_clear, write to the lowest-indexed free entry at the edge. Dispatch while out_full is dropped silently with no state change.
- Dispatch forwarding: if in_tagN != 0 and equals a nonzero CDB tag in the same cycle, store the CDB value with tag 0. ALU port has priority if both CDB tags match (not expected).
- Wakeup: at each edge, every busy entry with tN != 0 matching alu_cdb_tag or lsb_cdb_tag (nonzero) latches the value and clears tN.
- Select: combinational over registered state. Pick the lowest-indexed busy entry with t1==0 and t2==0. Wakeups and dispatches become selectable the following cycle.
- Issue: at the edge, load the selected entry's fields into the out_* registers and free the entry. With no candidate, load out_op=NOP, out_rob_tag=0 and all values 0.
- Latency: dispatch with ready operands at edge E gives issue on outputs after edge E+1. A broadcast at edge E gives the earliest issue after E+1.
- Outputs are registered, so the ALU result appears on the ALU CDB in the cycle after issue.
- in_clear: at the edge, free all entries and set out_op=NOP, out_rob_tag=0. Dispatch in the same cycle is ignored. Clear has priority over dispatch, wakeup and issue.
- Widths: no arithmetic; fields are stored and passed through unmodified.

Test Plan:
- Reset, then dispatch ADDI op, tags 0, v1=5, imm=7, rob=3 -> one cycle later out_op=ADDI, out_value1=5, out_imm=7, out_rob_tag=3; the cycle after, out_op=NOP.
- Dispatch ADD, t1=4, t2=0, v2=9; hold 3 cycles -> out_op stays NOP. Broadcast alu_cdb_tag=4, value=0x11 -> issue next cycle with out_value1=0x11, out_value2=9.
- Dispatch with in_tag2=6 in the same cycle as lsb_cdb_tag=6, value=0xAB -> issues next cycle with out_value2=0xAB (dispatch forwarding).
- Fill 16 ready entries while stalled by dependencies -> out_full=1. 17th dispatch dropped. Release entries -> issue order 0..15 by index, exactly 16 issues, no duplicate rob_tag.
- With 4 busy entries, assert in_clear with a simultaneous in_valid -> next cycle out_full=0, out_op=NOP, and no later issue of any cleared or simultaneously dispatched op.
- Hold rdy=0 for 5 cycles with a ready entry and a CDB broadcast -> no issue and no wakeup; outputs unchanged. Drop rst asynchronously mid-cycle -> outputs zero or NOP immediately.
